dmem_pipe: RTL and testbench
============================

DMEM_PIPE -- requirements
Module: dmem_pipe

Interface
REQ-001 SHALL provide parameter DATA_W, default 16, data word width in bits; legal values are multiples of 8.
REQ-002 SHALL provide parameter DMEM_DEPTH, default 10, address width in bits; the array has 2**DMEM_DEPTH words.
REQ-003 SHALL provide parameter OUT_REG, default 0, which adds an output register stage when 1; legal values are 0 and 1.
REQ-004 SHALL derive localparam BE_W = DATA_W/8, the number of byte lanes.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset; synchronous, active-high.
REQ-007 req_i  input  1  access request, sampled at the rising edge.
REQ-008 we_i  input  1  write when 1, read when 0; qualified by req_i.
REQ-009 addr_i  input  DMEM_DEPTH  word address.
REQ-010 wdata_i  input  DATA_W  write data.
REQ-011 be_i  input  BE_W  byte enables; bit k selects wdata_i[8k+7:8k].
REQ-012 ready_o  output  1  access accepted this cycle when req_i=1.
REQ-013 rvalid_o  output  1  single-cycle pulse; rdata_o is valid.
REQ-014 rdata_o  output  DATA_W  read data.
REQ-015 init_done_o  output  1  high once the post-reset clear has completed.

Function
REQ-016 SHALL implement a two-state FSM: CLEAR and RUN; reset enters CLEAR with clear address counter at 0.
REQ-017 SHALL, in CLEAR, write all-zero to the word at the counter each cycle and increment the counter; CLEAR lasts exactly 2**DMEM_DEPTH cycles.
REQ-018 SHALL transition CLEAR->RUN in the cycle after the write to address 2**DMEM_DEPTH-1; RUN is left only by reset.
REQ-019 SHALL drive ready_o=0 and init_done_o=0 in CLEAR, and ready_o=1 and init_done_o=1 in RUN.
REQ-020 SHALL ignore req_i while in CLEAR: no array change and no rvalid_o.
REQ-021 SHALL accept an access in each cycle where req_i=1 and ready_o=1; back-to-back accesses are accepted every cycle.
REQ-022 SHALL, on an accepted write, update only the byte lanes with be_i[k]=1; be_i=0 leaves the word unchanged; a write produces no rvalid_o.
REQ-023 SHALL, on an accepted read, assert rvalid_o with the word contents 1 cycle after acceptance when OUT_REG=0, and 2 cycles after acceptance when OUT_REG=1.
REQ-024 SHALL return, for a read accepted the cycle after a write to the same address, the newly written data; no stale-data hazard across consecutive accesses.
REQ-025 SHALL hold rdata_o at the last returned value while rvalid_o=0.
REQ-026 SHALL treat addr_i as modulo 2**DMEM_DEPTH; there is no out-of-range case.

Reset
REQ-027 SHALL set, on rst=1: ready_o=0, init_done_o=0, rvalid_o=0, rdata_o=0, FSM=CLEAR, clear counter=0, and all in-flight read pipeline valids=0.
REQ-028 SHALL, on reset asserted mid-CLEAR or mid-RUN, squash pending read returns and restart the clear from address 0; array contents are not guaranteed until init_done_o=1.
REQ-029 SHALL hold ready_o=0 for the whole duration that rst=1, regardless of req_i.

Verification
REQ-030 DATA_W=16, DMEM_DEPTH=4, OUT_REG=0: release rst -> ready_o=0 for exactly 16 cycles, then ready_o=1 and init_done_o=1; a read of every address returns 0x0000.
REQ-031 Write addr 3 with 0xBEEF and be=2'b11, then write addr 3 with 0x1234 and be=2'b01, then read addr 3 -> rdata_o=0xBE34 with rvalid_o exactly 1 cycle after the read is accepted.
REQ-032 OUT_REG=1: reads of addr 1, 2, 3 in consecutive cycles holding 0x0011, 0x0022, 0x0033 -> rvalid_o high for 3 consecutive cycles starting 2 cycles after the first read, returning the data in order; rdata_o holds 0x0033 afterwards.
REQ-033 Write addr 5 with 0xA5A5, read addr 5 in the next cycle -> 0xA5A5 returned; a write with be=2'b00 to addr 5 followed by a read -> still 0xA5A5.
REQ-034 Issue a read, then assert rst for 1 cycle before rvalid_o is due -> no rvalid_o pulse; the clear restarts (16 cycles with ready_o=0) and addr 5 then reads 0x0000.
REQ-035 Hold req_i=1 with we_i=1 and data 0xFFFF throughout CLEAR -> no write takes effect; all words read 0x0000 after init_done_o=1.

Source files
------------

// File: rtl/dmem_pipe.sv
// Byte-enabled single-port data memory with post-reset clear
// and a one- or two-stage registered read return path.
module dmem_pipe #(
  parameter int DATA_W     = 16,
  parameter int DMEM_DEPTH = 10,
  parameter int OUT_REG    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [DMEM_DEPTH-1:0] addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [DATA_W/8-1:0]   be_i,
  output logic                  ready_o,
  output logic                  rvalid_o,
  output logic [DATA_W-1:0]     rdata_o,
  output logic                  init_done_o
);

  localparam int BE_W  = DATA_W / 8;
  localparam int WORDS = 2 ** DMEM_DEPTH;

  typedef enum logic {
    CLEAR,
    RUN
  } state_e;

  state_e                state_q, state_d;
  logic [DMEM_DEPTH-1:0] cnt_q, cnt_d;
  logic                  acc_rd, acc_wr;
  logic [DATA_W-1:0]     mem_q [WORDS];
  logic                  v1_q;
  logic [DATA_W-1:0]     d1_q;

  // Next state, clear counter and handshake outputs
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ready_o     = 1'b0;
    init_done_o = 1'b0;
    unique case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = RUN;
      end
      RUN: begin
        ready_o     = ~rst;
        init_done_o = ~rst;
      end
      default: state_d = CLEAR;
    endcase
    acc_rd = req_i & ready_o & ~we_i;
    acc_wr = req_i & ready_o & we_i;
  end

  // FSM state and clear counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Array: zero-fill while clearing, lane-masked writes when running
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR) begin
        mem_q[cnt_q] <= '0;
      end else if (acc_wr) begin
        for (int k = 0; k < BE_W; k++) begin
          if (be_i[k]) mem_q[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
    end
  end

  // First read stage: data captured at acceptance, held otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      d1_q <= '0;
    end else begin
      v1_q <= acc_rd;
      if (acc_rd) d1_q <= mem_q[addr_i];
    end
  end

  if (OUT_REG == 1) begin : g_oreg
    logic              v2_q;
    logic [DATA_W-1:0] d2_q;

    // Optional second read stage
    always_ff @(posedge clk) begin
      if (rst) begin
        v2_q <= 1'b0;
        d2_q <= '0;
      end else begin
        v2_q <= v1_q;
        if (v1_q) d2_q <= d1_q;
      end
    end

    assign rvalid_o = v2_q;
    assign rdata_o  = d2_q;
  end else begin : g_noreg
    assign rvalid_o = v1_q;
    assign rdata_o  = d1_q;
  end

endmodule

// File: tb/tb_dmem_pipe.sv
// Random and directed checks of dmem_pipe, OUT_REG=0 and 1
// side by side, against a cycle-counted memory model.
module tb_dmem_pipe;

  logic        clk = 1'b0;
  logic        rst, req, we;
  logic [3:0]  addr;
  logic [15:0] wdata;
  logic [1:0]  be;
  logic        rdy0, rv0, ini0, rdy1, rv1, ini1;
  logic [15:0] rd0, rd1;

  int n_chk = 0;
  int n_fail = 0;

  logic [15:0] mdl [16];
  int          clr_left;
  int          cyc;
  int          dq0 [$], dq1 [$];
  logic [15:0] xq0 [$], xq1 [$];
  logic [15:0] last0, last1;

  always #5 clk = ~clk;

  dmem_pipe #(.DATA_W(16), .DMEM_DEPTH(4), .OUT_REG(0)) u0 (
    .clk(clk), .rst(rst), .req_i(req), .we_i(we),
    .addr_i(addr), .wdata_i(wdata), .be_i(be),
    .ready_o(rdy0), .rvalid_o(rv0), .rdata_o(rd0),
    .init_done_o(ini0)
  );

  dmem_pipe #(.DATA_W(16), .DMEM_DEPTH(4), .OUT_REG(1)) u1 (
    .clk(clk), .rst(rst), .req_i(req), .we_i(we),
    .addr_i(addr), .wdata_i(wdata), .be_i(be),
    .ready_o(rdy1), .rvalid_o(rv1), .rdata_o(rd1),
    .init_done_o(ini1)
  );

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h",
               tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: drive, check at negedge, advance model.
  task automatic step(input bit r, input bit q, input bit w,
                      input logic [3:0] a, input logic [15:0] d,
                      input logic [1:0] b);
    bit exp_rdy;
    bit ev;
    rst = r; req = q; we = w; addr = a; wdata = d; be = b;
    @(negedge clk);
    exp_rdy = !r && clr_left == 0;
    chk("ready0", {15'd0, rdy0}, {15'd0, exp_rdy});
    chk("ready1", {15'd0, rdy1}, {15'd0, exp_rdy});
    chk("init0", {15'd0, ini0}, {15'd0, exp_rdy});
    chk("init1", {15'd0, ini1}, {15'd0, exp_rdy});
    ev = dq0.size() > 0 && dq0[0] == cyc;
    if (ev) begin
      last0 = xq0.pop_front();
      void'(dq0.pop_front());
    end
    chk("rvalid0", {15'd0, rv0}, {15'd0, ev});
    chk("rdata0", rd0, last0);
    ev = dq1.size() > 0 && dq1[0] == cyc;
    if (ev) begin
      last1 = xq1.pop_front();
      void'(dq1.pop_front());
    end
    chk("rvalid1", {15'd0, rv1}, {15'd0, ev});
    chk("rdata1", rd1, last1);
    if (r) begin
      dq0.delete(); xq0.delete();
      dq1.delete(); xq1.delete();
      last0 = '0; last1 = '0;
      clr_left = 16;
      for (int i = 0; i < 16; i++) mdl[i] = '0;
    end else if (clr_left > 0) begin
      clr_left--;
    end else if (q && w) begin
      for (int k = 0; k < 2; k++)
        if (b[k]) mdl[a][8*k +: 8] = d[8*k +: 8];
    end else if (q) begin
      dq0.push_back(cyc + 1); xq0.push_back(mdl[a]);
      dq1.push_back(cyc + 2); xq1.push_back(mdl[a]);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic rd(input logic [3:0] a);
    step(0, 1, 0, a, 16'h0, 2'b00);
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d,
                    input logic [1:0] b);
    step(0, 1, 1, a, d, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 4'h0, 16'h0, 2'b00);
  endtask

  initial begin
    cyc = 0;
    clr_left = 16;
    last0 = '0; last1 = '0;
    for (int i = 0; i < 16; i++) mdl[i] = '0;
    rst = 1; req = 1; we = 1; addr = 0; wdata = 16'hFFFF; be = 2'b11;
    @(posedge clk);
    #1;
    cyc = 1;
    // reset held with a pending write request, then writes through clear
    for (int i = 0; i < 3; i++) step(1, 1, 1, 4'(i), 16'hFFFF, 2'b11);
    for (int i = 0; i < 16; i++) step(0, 1, 1, 4'(i), 16'hFFFF, 2'b11);
    for (int i = 0; i < 16; i++) rd(4'(i));
    idle(2);
    // partial byte write merge
    wr(3, 16'hBEEF, 2'b11);
    wr(3, 16'h1234, 2'b01);
    rd(3);
    idle(2);
    chk("merge", rd0, 16'hBE34);
    // back-to-back reads in order
    wr(1, 16'h0011, 2'b11);
    wr(2, 16'h0022, 2'b11);
    wr(3, 16'h0033, 2'b11);
    rd(1); rd(2); rd(3);
    idle(3);
    chk("hold1", rd1, 16'h0033);
    // read right after write, masked write leaves word alone
    wr(5, 16'hA5A5, 2'b11);
    rd(5);
    wr(5, 16'h0000, 2'b00);
    rd(5);
    idle(2);
    chk("be0", rd0, 16'hA5A5);
    // reset squashes an in-flight read and restarts the clear
    rd(5);
    step(1, 0, 0, 4'h0, 16'h0, 2'b00);
    idle(16);
    rd(5);
    idle(2);
    chk("clr5", rd1, 16'h0000);
    // random traffic with occasional reset
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 79) == 0, 1'($urandom), 1'($urandom),
           4'($urandom), 16'($urandom), 2'($urandom));
    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
